// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Imported by the wait counter and the arbiter top.
package mem_arb_pkg;

    // Width of the access-latency down-counter (WAIT_CYCLES up to 15).
    localparam int unsigned CNT_W = 4;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } arb_state_t;

    // Identity of the requester owning the memory access.
    typedef enum logic {
        GNT_INSTR,
        GNT_DATA
    } arb_grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core/memory-side bundle for mem_port_arbiter: fetch port, data port and
// the single-port memory strobes. The arbiter connects through 'slave';
// the surrounding core + memory environment uses 'master'.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);

    // Fetch stage
    logic          InstrReq;
    logic [AW-1:0] InstrAdr;
    logic [DW-1:0] InstrRdata;
    logic          InstrValid;

    // Memory stage
    logic          DataReq;
    logic          DataWe;
    logic [AW-1:0] DataAdr;
    logic [DW-1:0] DataWdata;
    logic [DW-1:0] DataRdata;
    logic          DataValid;

    // Pipeline stalls
    logic          StallF;
    logic          StallM;

    // Unified memory
    logic          MemEn;
    logic          MemWe;
    logic [AW-1:0] MemAdr;
    logic [DW-1:0] MemWdata;
    logic [DW-1:0] MemRdata;

    modport slave (
        input  InstrReq, InstrAdr,
        input  DataReq, DataWe, DataAdr, DataWdata,
        input  MemRdata,
        output InstrRdata, InstrValid,
        output DataRdata, DataValid,
        output StallF, StallM,
        output MemEn, MemWe, MemAdr, MemWdata
    );

    modport master (
        output InstrReq, InstrAdr,
        output DataReq, DataWe, DataAdr, DataWdata,
        output MemRdata,
        input  InstrRdata, InstrValid,
        input  DataRdata, DataValid,
        input  StallF, StallM,
        input  MemEn, MemWe, MemAdr, MemWdata
    );

endinterface

// File: rtl/mem_port_arbiter_wait_counter.sv
// Loadable down-counter with zero flag, used to time fixed-latency memory
// accesses. Decrement saturates at zero; load has priority over decrement.
module arb_wait_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: load, saturating decrement, or hold.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Counter register, cleared by asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port unified memory between the fetch stage
// (instruction requester) and the memory stage (data requester).
// Sequences fixed-latency accesses, returns read data with a one-cycle
// Valid pulse, and produces per-stage stall signals.
//
// Optional build macro: ARB_FAIRNESS_EN
//   defined   - when both requesters are eligible, the one not granted last
//               wins; a last-grant register tracks every grant.
//   undefined - strict data-over-instruction priority, no last-grant state.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    arb_state_t    state_q;
    arb_grant_t    gnt_q;        // requester owning the current/last access
    logic          acc_we_q;     // current access is a store

    logic          mem_en_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_adr_q;
    logic [DW-1:0] mem_wdata_q;

    logic [DW-1:0] instr_rdata_q;
    logic [DW-1:0] data_rdata_q;
    logic          instr_valid_q;
    logic          data_valid_q;

`ifdef ARB_FAIRNESS_EN
    arb_grant_t    last_q;
`endif

    logic          instr_elig;
    logic          data_elig;
    logic          grant_vld;
    arb_grant_t    grant_who;
    logic          cnt_zero;

    // Grant decision: only in IDLE or DONE; in DONE the requester being
    // answered this cycle is excluded so its still-high request is ignored.
    always_comb begin
        instr_elig = 1'b0;
        data_elig  = 1'b0;
        case (state_q)
            IDLE: begin
                instr_elig = bus.InstrReq;
                data_elig  = bus.DataReq;
            end
            DONE: begin
                instr_elig = bus.InstrReq && (gnt_q != GNT_INSTR);
                data_elig  = bus.DataReq  && (gnt_q != GNT_DATA);
            end
            default: ;
        endcase

        grant_vld = instr_elig | data_elig;
`ifdef ARB_FAIRNESS_EN
        if (instr_elig && data_elig) begin
            grant_who = (last_q == GNT_DATA) ? GNT_INSTR : GNT_DATA;
        end else begin
            grant_who = data_elig ? GNT_DATA : GNT_INSTR;
        end
`else
        grant_who = data_elig ? GNT_DATA : GNT_INSTR;
`endif
    end

    // Access latency: loaded with WAIT_CYCLES on grant, counts down in WAIT.
    arb_wait_counter u_wait_cnt (
        .clk        (clk),
        .rst        (reset),
        .load_i     (grant_vld),
        .load_val_i (CNT_W'(WAIT_CYCLES)),
        .dec_i      (state_q == WAIT),
        .zero_o     (cnt_zero)
    );

    // Arbiter FSM with registered memory strobes, read data and Valid pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            gnt_q         <= GNT_INSTR;
            acc_we_q      <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_adr_q     <= '0;
            mem_wdata_q   <= '0;
            instr_rdata_q <= '0;
            data_rdata_q  <= '0;
            instr_valid_q <= 1'b0;
            data_valid_q  <= 1'b0;
`ifdef ARB_FAIRNESS_EN
            last_q        <= GNT_INSTR;
`endif
        end else begin
            // Strobes and Valid pulses last one cycle unless re-asserted.
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            instr_valid_q <= 1'b0;
            data_valid_q  <= 1'b0;

            case (state_q)
                IDLE, DONE: begin
                    if (grant_vld) begin
                        state_q  <= WAIT;
                        gnt_q    <= grant_who;
                        mem_en_q <= 1'b1;
`ifdef ARB_FAIRNESS_EN
                        last_q   <= grant_who;
`endif
                        if (grant_who == GNT_DATA) begin
                            mem_we_q    <= bus.DataWe;
                            acc_we_q    <= bus.DataWe;
                            mem_adr_q   <= bus.DataAdr;
                            mem_wdata_q <= bus.DataWdata;
                        end else begin
                            acc_we_q    <= 1'b0;
                            mem_adr_q   <= bus.InstrAdr;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end

                WAIT: begin
                    if (cnt_zero) begin
                        state_q <= DONE;
                        if (gnt_q == GNT_DATA) begin
                            data_valid_q <= 1'b1;
                            if (!acc_we_q) begin
                                data_rdata_q <= bus.MemRdata;
                            end
                        end else begin
                            instr_valid_q <= 1'b1;
                            instr_rdata_q <= bus.MemRdata;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.MemEn      = mem_en_q;
    assign bus.MemWe      = mem_we_q;
    assign bus.MemAdr     = mem_adr_q;
    assign bus.MemWdata   = mem_wdata_q;
    assign bus.InstrRdata = instr_rdata_q;
    assign bus.InstrValid = instr_valid_q;
    assign bus.DataRdata  = data_rdata_q;
    assign bus.DataValid  = data_valid_q;
    assign bus.StallF     = bus.InstrReq & ~instr_valid_q;
    assign bus.StallM     = bus.DataReq  & ~data_valid_q;

endmodule
